memory_stage: RTL and testbench

//  Memory (M) stage of the 5-stage pipeline and the consumer of the Execute stage's M-side outputs.
//  - Takes the ALU result, store data and control from the E/M register.
//  - Performs data-memory stores and loads against a synchronous-read data memory.
//  - Drives the M/W pipeline register that feeds writeback.
//  - Loads take one extra cycle; during that cycle the block stalls upstream via stall_M.

---
 rtl/memory_stage_pkg.sv | 15 +
 rtl/memory_stage_data_mem.sv | 23 ++
 rtl/memory_stage.sv | 105 ++++++++++
 tb/tb_memory_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the pipeline's memory stage: result-select encodings,
// register-index width and the M-stage FSM states.
package memory_stage_pkg;

  localparam logic RES_ALU = 1'b0;
  localparam logic RES_MEM = 1'b1;

  localparam int REG_W = 5;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } m_state_e;

endpackage : memory_stage_pkg

// File: rtl/memory_stage_data_mem.sv
// Single-port data memory: synchronous write and synchronous (registered) read.
// Contents are never reset.
module data_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wd;
    end
    rd <= mem[addr];
  end

endmodule : data_mem

// File: rtl/memory_stage.sv
// Memory stage: stores/loads against data_mem, stalls upstream for the extra
// load cycle, and drives the M/W pipeline register.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_M,
  input  logic [DATA_W-1:0] Alu_out_M,
  input  logic [DATA_W-1:0] WD_M,
  input  logic              DM_Write_M,
  input  logic              Result_M,
  input  logic              RF_WE_M,
  input  logic [REG_W-1:0]  Rd_M,
  output logic              stall_M,
  output logic              valid_W,
  output logic [DATA_W-1:0] Result_W,
  output logic              RF_WE_W,
  output logic [REG_W-1:0]  Rd_W
);

  m_state_e state_q, state_d;

  logic              is_store_p0;
  logic              is_load_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              mem_we_p0;
  logic [DATA_W-1:0] mem_rd_p1;

  // Stage p0: decode M-side inputs; byte-offset and upper address bits drop out
  assign addr_p0     = Alu_out_M[ADDR_W+1:2];
  assign is_store_p0 = valid_M & DM_Write_M;
  assign is_load_p0  = valid_M & ~DM_Write_M & (Result_M == RES_MEM);
  assign mem_we_p0   = rst & (state_q == IDLE) & is_store_p0;

  data_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk  (clk),
    .we   (mem_we_p0),
    .addr (addr_p0),
    .wd   (WD_M),
    .rd   (mem_rd_p1)
  );

  always_comb begin
    state_d = state_q;
    stall_M = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_load_p0) begin
          stall_M = rst;
          state_d = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stage p1: M/W register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      valid_W  <= 1'b0;
      RF_WE_W  <= 1'b0;
      Result_W <= '0;
      Rd_W     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (valid_M && (DM_Write_M || (Result_M == RES_ALU))) begin
            valid_W  <= 1'b1;
            RF_WE_W  <= RF_WE_M;
            Result_W <= Alu_out_M;
            Rd_W     <= Rd_M;
          end else begin
            valid_W <= 1'b0;
            RF_WE_W <= 1'b0;
          end
        end
        LOAD_WAIT: begin
          valid_W  <= 1'b1;
          RF_WE_W  <= RF_WE_M;
          Result_W <= mem_rd_p1;
          Rd_W     <= Rd_M;
        end
        default: begin
          valid_W <= 1'b0;
          RF_WE_W <= 1'b0;
        end
      endcase
    end
  end

endmodule : memory_stage

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a driver pushes expected writeback values
// computed from an array model of memory; a monitor pops them as valid_W appears.
module tb_memory_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam int K_BUB = 0, K_ALU = 1, K_ST = 2, K_LD = 3, K_CONF = 4;

  typedef struct {
    logic [31:0] res;
    logic        we;
    logic [4:0]  rd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        valid_M;
  logic [31:0] Alu_out_M;
  logic [31:0] WD_M;
  logic        DM_Write_M;
  logic        Result_M;
  logic        RF_WE_M;
  logic [4:0]  Rd_M;
  logic        stall_M;
  logic        valid_W;
  logic [31:0] Result_W;
  logic        RF_WE_W;
  logic [4:0]  Rd_W;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  int          vectors = 0;
  int          miscompares = 0;

  memory_stage #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_M    (valid_M),
    .Alu_out_M  (Alu_out_M),
    .WD_M       (WD_M),
    .DM_Write_M (DM_Write_M),
    .Result_M   (Result_M),
    .RF_WE_M    (RF_WE_M),
    .Rd_M       (Rd_M),
    .stall_M    (stall_M),
    .valid_W    (valid_W),
    .Result_W   (Result_W),
    .RF_WE_W    (RF_WE_W),
    .Rd_W       (Rd_W)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected entry per valid writeback.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (valid_W === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_wb: got Result_W %h with empty scoreboard", Result_W);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("Result_W", Result_W, e.res);
          chk("RF_WE_W", {31'd0, RF_WE_W}, {31'd0, e.we});
          chk("Rd_W", {27'd0, Rd_W}, {27'd0, e.rd});
        end
      end else begin
        chk("RF_WE_W_bubble", {31'd0, RF_WE_W}, 32'd0);
      end
    end
  end

  task automatic issue(input int kind, input logic [31:0] alu, input logic [31:0] wd,
                       input logic rfwe, input logic [4:0] rd);
    int   idx;
    exp_t e;
    valid_M    = (kind != K_BUB);
    Alu_out_M  = alu;
    WD_M       = wd;
    DM_Write_M = (kind == K_ST) || (kind == K_CONF);
    Result_M   = (kind == K_LD) || (kind == K_CONF);
    RF_WE_M    = rfwe;
    Rd_M       = rd;
    idx = int'((alu / 4) % DEPTH);
    #1;
    if (kind == K_LD) begin
      chk("stall_load", {31'd0, stall_M}, 32'd1);
      e = '{res: ref_mem[idx], we: rfwe, rd: rd};
      exp_q.push_back(e);
      @(posedge clk); #1;
      chk("stall_wait", {31'd0, stall_M}, 32'd0);
    end else begin
      chk("stall_none", {31'd0, stall_M}, 32'd0);
      if (kind != K_BUB) begin
        e = '{res: alu, we: rfwe, rd: rd};
        exp_q.push_back(e);
      end
      if (kind == K_ST || kind == K_CONF) ref_mem[idx] = wd;
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid_W"}, {31'd0, valid_W}, 32'd0);
    chk({tag, "_Result_W"}, Result_W, 32'd0);
    chk({tag, "_RF_WE_W"}, {31'd0, RF_WE_W}, 32'd0);
    chk({tag, "_Rd_W"}, {27'd0, Rd_W}, 32'd0);
    chk({tag, "_stall_M"}, {31'd0, stall_M}, 32'd0);
  endtask

  initial begin
    int wait_cycles;
    rst = 1'b0;
    valid_M = 1'b0; Alu_out_M = '0; WD_M = '0; DM_Write_M = 1'b0;
    Result_M = 1'b0; RF_WE_M = 1'b0; Rd_M = '0;

    // Reset held with toggling inputs, including a load that would otherwise stall.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      valid_M    = 1'b1;
      Alu_out_M  = $urandom;
      WD_M       = $urandom;
      DM_Write_M = (i % 3 == 2);
      Result_M   = 1'b1;
      RF_WE_M    = 1'b1;
      Rd_M       = 5'(i + 1);
      #1;
      chk_reset_outputs("reset");
    end
    valid_M = 1'b0; DM_Write_M = 1'b0; Result_M = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_valid_W", {31'd0, valid_W}, 32'd0);

    // ALU op.
    issue(K_ALU, 32'h9, 32'h0, 1'b1, 5'd3);

    // Fill memory so every later load has a known expectation.
    for (int i = 0; i < DEPTH; i++) begin
      issue(K_ST, 32'(i * 4), $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    // Store then load same address, back to back.
    issue(K_ST, 32'h10, 32'hDEADBEEF, 1'b0, 5'd0);
    issue(K_LD, 32'h10, 32'h0, 1'b1, 5'd7);

    // Misaligned store, then load through wrapped address hitting the same word.
    issue(K_ST, 32'h11, 32'hA5, 1'b0, 5'd0);
    issue(K_LD, 32'h410, 32'h0, 1'b1, 5'd9);

    // Store-and-load conflict behaves as a store.
    issue(K_CONF, 32'h20, 32'h1234_5678, 1'b1, 5'd11);
    issue(K_LD, 32'h20, 32'h0, 1'b1, 5'd12);

    // Reset asserted in LOAD_WAIT drops the pending load.
    valid_M = 1'b1; Alu_out_M = 32'h10; DM_Write_M = 1'b0; Result_M = 1'b1;
    RF_WE_M = 1'b1; Rd_M = 5'd13;
    #1;
    chk("rstload_stall", {31'd0, stall_M}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rstload");
    valid_M = 1'b0; Result_M = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstload_after_valid_W", {31'd0, valid_W}, 32'd0);
    issue(K_LD, 32'h10, 32'h0, 1'b1, 5'd14);

    // Randomized mix with full-width addresses.
    for (int i = 0; i < 400; i++) begin
      issue(int'($urandom_range(0, 4)), $urandom, $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    valid_M = 1'b0; DM_Write_M = 1'b0; Result_M = 1'b0;
    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d writebacks missing, required 0", exp_q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_memory_stage
